// File: rtl/frame_scrambler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_scrambler_pkg
// Brief    : Shared 802.11a transmit scrambler constants, FSM type, feedback.
// Revision : 1.0 - initial release
// ============================================================================
package frame_scrambler_pkg;

    localparam int LFSR_W = 7;
    localparam int TAP_HI = 7;
    localparam int TAP_LO = 4;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

    // State is held as x7..x1 in bits [6:0], so tap xN lives at bit N-1.
    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
        return s[TAP_HI-1] ^ s[TAP_LO-1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/scrambler_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : scrambler_lfsr
// Brief    : 7-bit x^7+x^4+1 LFSR with load, advance and combinational feedback.
// Revision : 1.0 - initial release
// ============================================================================
module scrambler_lfsr
    import frame_scrambler_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_STATE = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_advance,
    output logic              o_fb
);

    logic [LFSR_W-1:0] r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET_STATE;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_advance) begin
            r_state <= {r_state[LFSR_W-2:0], o_fb};
        end
    end

    assign o_fb = lfsr_fb(r_state);

endmodule
`default_nettype wire

// File: rtl/frame_scrambler.sv
`default_nettype none
// ============================================================================
// Module   : frame_scrambler
// Brief    : 802.11a TX data scrambler with valid/ready on both sides.
//            Define SCRAMBLER_TAIL_EN to append TAIL_BITS forced-zero tail bits.
// Revision : 1.0 - initial release
// ============================================================================
module frame_scrambler
    import frame_scrambler_pkg::*;
#(
    parameter int TAIL_BITS = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_data,
    input  logic              i_valid,
    input  logic              i_last,
    output logic              o_ready,
    output logic              o_data,
    output logic              o_valid,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_busy
);

`ifdef SCRAMBLER_TAIL_EN
    localparam bit c_TAIL_EN = 1'b1;
`else
    localparam bit c_TAIL_EN = 1'b0;
`endif
    localparam int CNT_W = $clog2(TAIL_BITS + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_tail_cnt;
    logic              r_out_data;
    logic              r_out_valid;
    logic              r_out_last;
    logic              w_slot_free;
    logic              w_ready;
    logic              w_in_hs;
    logic              w_tail_fire;
    logic              w_advance;
    logic              w_load;
    logic              w_bit;
    logic              w_bit_last;
    logic              w_fb;
    logic [LFSR_W-1:0] w_seed;

    // The output register can take a new bit when empty or draining this cycle.
    assign w_slot_free = ~r_out_valid | i_ready;
    assign w_in_hs     = i_valid & w_ready;
    assign w_advance   = w_in_hs | w_tail_fire;
    assign w_load      = (r_state == ST_IDLE) & i_start;
    assign w_seed      = (i_seed == '0) ? DEFAULT_SEED : i_seed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_nxt = ST_DATA;
            ST_DATA: if (w_in_hs & i_last) w_state_nxt = c_TAIL_EN ? ST_TAIL : ST_IDLE;
            ST_TAIL: if (w_tail_fire & (r_tail_cnt == CNT_W'(1))) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready     = 1'b0;
        w_tail_fire = 1'b0;
        w_bit       = 1'b0;
        w_bit_last  = 1'b0;
        case (r_state)
            ST_DATA: begin
                w_ready    = w_slot_free;
                w_bit      = i_data ^ w_fb;
                w_bit_last = i_last & ~c_TAIL_EN;
            end
            ST_TAIL: begin
                w_tail_fire = w_slot_free;
                w_bit_last  = (r_tail_cnt == CNT_W'(1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tail_cnt <= '0;
        end else if (w_in_hs & i_last) begin
            r_tail_cnt <= CNT_W'(TAIL_BITS);
        end else if (w_tail_fire) begin
            r_tail_cnt <= r_tail_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_advance) begin
            r_out_data  <= w_bit;
            r_out_last  <= w_bit_last;
            r_out_valid <= 1'b1;
        end else if (i_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    scrambler_lfsr #(
        .RESET_STATE (DEFAULT_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_seed    (w_seed),
        .i_advance (w_advance),
        .o_fb      (w_fb)
    );

    assign o_ready = w_ready;
    assign o_data  = r_out_data;
    assign o_valid = r_out_valid;
    assign o_last  = r_out_last;
    assign o_busy  = (r_state != ST_IDLE) | r_out_valid;

endmodule
`default_nettype wire
